// File: rtl/mem_access_unit_if.sv
// Bus bundle for mem_access_unit: CPU-side req/done handshake and BRAM-side word port.
// slave = the access unit, master = control FSM plus BRAM.
interface mem_access_unit_if #(
    parameter int unsigned WORDS      = 10,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  req_i;
    logic                  we_i;
    logic [31:0]           addr_i;
    logic [1:0]            size_i;
    logic                  unsigned_i;
    logic [DATA_WIDTH-1:0] wdata_i;
    logic [DATA_WIDTH-1:0] rdata_o;
    logic                  done_o;
    logic                  busy_o;
    logic                  misalign_o;
    logic [WORDS-1:0]      mem_addr_o;
    logic [DATA_WIDTH-1:0] mem_data_o;
    logic                  mem_wr_o;
    logic [DATA_WIDTH-1:0] mem_data_i;

    modport slave (
        input  req_i, we_i, addr_i, size_i, unsigned_i, wdata_i, mem_data_i,
        output rdata_o, done_o, busy_o, misalign_o, mem_addr_o, mem_data_o, mem_wr_o
    );

    modport master (
        output req_i, we_i, addr_i, size_i, unsigned_i, wdata_i, mem_data_i,
        input  rdata_o, done_o, busy_o, misalign_o, mem_addr_o, mem_data_o, mem_wr_o
    );
endinterface

// File: rtl/mem_access_unit.sv
// Byte-addressed load/store front end for a word-addressed BRAM (1-cycle registered read).
// Define MEM_RANGE_CHECK_EN to reject addresses with bits set above the BRAM range.
module mem_access_unit #(
    parameter int unsigned WORDS      = 10,
    parameter int unsigned DATA_WIDTH = 32
) (
    input logic              clk_i,
    input logic              reset_ni,
    mem_access_unit_if.slave bus
);

    localparam logic [2:0] StIdle = 3'd0;
    localparam logic [2:0] StRd   = 3'd1;
    localparam logic [2:0] StCap  = 3'd2;
    localparam logic [2:0] StWr   = 3'd3;
    localparam logic [2:0] StDone = 3'd4;
    localparam logic [2:0] StErr  = 3'd5;

    logic [2:0]            r_state;
    logic                  r_we;
    logic [1:0]            r_size;
    logic                  r_unsigned;
    logic [1:0]            r_lane;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_done;
    logic                  r_busy;
    logic                  r_misalign;
    logic [WORDS-1:0]      r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_data;
    logic                  r_mem_wr;

    logic                  w_misalign;
    logic                  w_range_err;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic [DATA_WIDTH-1:0] w_load;
    logic [DATA_WIDTH-1:0] w_merge;

    assign w_misalign = (bus.size_i == 2'b11) ||
                        (bus.size_i == 2'b01 && bus.addr_i[0]) ||
                        (bus.size_i == 2'b10 && bus.addr_i[1:0] != 2'b00);

`ifdef MEM_RANGE_CHECK_EN
    assign w_range_err = |bus.addr_i[31:WORDS+2];
`else
    // Upper address bits wrap silently.
    logic w_unused_addr_hi;
    assign w_unused_addr_hi = |bus.addr_i[31:WORDS+2];
    assign w_range_err      = 1'b0;
`endif

    always_comb begin
        w_byte = bus.mem_data_i[7:0];
        unique case (r_lane)
            2'd0: w_byte = bus.mem_data_i[7:0];
            2'd1: w_byte = bus.mem_data_i[15:8];
            2'd2: w_byte = bus.mem_data_i[23:16];
            2'd3: w_byte = bus.mem_data_i[31:24];
            default: w_byte = bus.mem_data_i[7:0];
        endcase
        w_half = r_lane[1] ? bus.mem_data_i[31:16] : bus.mem_data_i[15:0];
        unique case (r_size)
            2'b00:   w_load = r_unsigned ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
            2'b01:   w_load = r_unsigned ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
            default: w_load = bus.mem_data_i;
        endcase
    end

    // Read-modify-write: only the addressed lane(s) take new store data.
    always_comb begin
        w_merge = bus.mem_data_i;
        if (r_size == 2'b00) begin
            unique case (r_lane)
                2'd0: w_merge[7:0]   = r_wdata[7:0];
                2'd1: w_merge[15:8]  = r_wdata[7:0];
                2'd2: w_merge[23:16] = r_wdata[7:0];
                2'd3: w_merge[31:24] = r_wdata[7:0];
                default: w_merge = bus.mem_data_i;
            endcase
        end else if (r_size == 2'b01) begin
            if (r_lane[1]) w_merge[31:16] = r_wdata[15:0];
            else           w_merge[15:0]  = r_wdata[15:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            r_state    <= StIdle;
            r_we       <= 1'b0;
            r_size     <= 2'b00;
            r_unsigned <= 1'b0;
            r_lane     <= 2'b00;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
            r_misalign <= 1'b0;
            r_mem_addr <= '0;
            r_mem_data <= '0;
            r_mem_wr   <= 1'b1;
        end else begin
            r_done     <= 1'b0;
            r_misalign <= 1'b0;
            r_mem_wr   <= 1'b1;
            unique case (r_state)
                StIdle: begin
                    if (bus.req_i) begin
                        r_we       <= bus.we_i;
                        r_size     <= bus.size_i;
                        r_unsigned <= bus.unsigned_i;
                        r_lane     <= bus.addr_i[1:0];
                        r_wdata    <= bus.wdata_i;
                        r_mem_addr <= bus.addr_i[WORDS+1:2];
                        r_busy     <= 1'b1;
                        if (w_misalign || w_range_err) begin
                            r_state    <= StErr;
                            r_done     <= 1'b1;
                            r_misalign <= 1'b1;
                        end else if (bus.we_i && bus.size_i == 2'b10) begin
                            r_state    <= StWr;
                            r_mem_data <= bus.wdata_i;
                            r_mem_wr   <= 1'b0;
                        end else begin
                            r_state <= StRd;
                        end
                    end
                end
                StRd: r_state <= StCap;
                StCap: begin
                    if (r_we) begin
                        r_state    <= StWr;
                        r_mem_data <= w_merge;
                        r_mem_wr   <= 1'b0;
                    end else begin
                        r_state <= StDone;
                        r_rdata <= w_load;
                        r_done  <= 1'b1;
                    end
                end
                StWr: begin
                    r_state <= StDone;
                    r_done  <= 1'b1;
                end
                default: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rdata_o    = r_rdata;
    assign bus.done_o     = r_done;
    assign bus.busy_o     = r_busy;
    assign bus.misalign_o = r_misalign;
    assign bus.mem_addr_o = r_mem_addr;
    assign bus.mem_data_o = r_mem_data;
    assign bus.mem_wr_o   = r_mem_wr;

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store front end placed directly upstream of the 1Kx32 word-addressed BRAM Memory in the multicycle RV32I datapath.
- Converts CPU byte-addressed LB/LH/LW/LBU/LHU/SB/SH/SW requests into word-level BRAM cycles. Memory write enable is active low and read data is registered with 1-cycle latency.
- Sub-word stores use read-modify-write. Loads are lane-extracted and sign- or zero-extended.
- Req/done handshake toward the control FSM.

Parameters:
- WORDS, 10, log2 of BRAM depth in 32-bit words; mem_addr_o width.
- DATA_WIDTH, 32, data width; the design supports only 32.

Ports:
- clk_i  in  1  clock, pos-edge
- reset_ni  in  1  synchronous, active-low reset
- req_i  in  1  start access; sampled only in IDLE
- we_i  in  1  1=store, 0=load
- addr_i  in  32  byte address
- size_i  in  2  00 byte, 01 half, 10 word, 11 illegal
- unsigned_i  in  1  1=zero-extend load
- wdata_i  in  32  store data, right-aligned
- rdata_o  out  32  extended load result
- done_o  out  1  one-cycle completion pulse
- busy_o  out  1  high in any state except IDLE
- misalign_o  out  1  one-cycle error pulse, coincident with done_o
- mem_addr_o  out  WORDS  BRAM word address
- mem_data_o  out  32  BRAM write data
- mem_wr_o  out  1  BRAM write enable, active low
- mem_data_i  in  32  BRAM registered read data

Behaviour:
- Reset (reset_ni=0 at an edge): state IDLE; rdata_o=0, done_o=0, misalign_o=0, mem_addr_o=0, mem_data_o=0, mem_wr_o=1.
- Reset mid-operation aborts the access; the next cycle is IDLE with mem_wr_o=1.
- A write whose WR cycle coincides with the reset edge is committed by the BRAM; this is accepted behaviour.
- Accept: in IDLE with req_i=1, latch addr_i, size_i, we_i, unsigned_i, wdata_i. mem_addr_o <= addr_i[WORDS+1:2].
- Address bits above WORDS+1 are ignored (wrap).
- req_i while busy is ignored, not queued.
- Misalignment: half with addr[0]=1, word with addr[1:0]!=0, or size 11.
- States:
  - IDLE: misaligned -> ERR; load or sub-word store -> RD; word store -> WR (mem_data_o <= wdata).
  - RD: BRAM samples mem_addr_o -> CAP.
  - CAP: capture mem_data_i. Load -> DONE, with rdata_o <= extracted value. Store -> WR, with mem_data_o <= merged word.
  - WR: mem_wr_o=0 for exactly this cycle -> DONE.
  - DONE: done_o=1 -> IDLE.
  - ERR: done_o=1, misalign_o=1, no BRAM write, rdata_o unchanged -> IDLE.
- All outputs are registered. mem_wr_o is 1 in every state except WR.
- Latency (accept edge to done_o high): load 3 clocks, word store 2, sub-word store 4, error 1.
- Back-to-back: req_i may be high in the DONE cycle; it is accepted on the edge after DONE, when the unit is in IDLE.
- Lanes are little-endian.
  - Byte lane = addr[1:0]; half lane = addr[1].
  - Load: selected lane sign-extended, or zero-extended if unsigned_i=1; unsigned_i is ignored for words.
  - Store merge: replace only the addressed lane(s) with wdata_i[7:0] or wdata_i[15:0]; other lanes retain the read value.

Optional Feature:
- MEM_RANGE_CHECK_EN defined: an access with any nonzero addr_i bit above WORDS+1 is treated as an error (ERR path: misalign_o=1, done_o=1, no BRAM write).
- Undefined: upper bits are ignored and the address wraps.

Test Plan:
- Preload word 10=0x80FF3312.
  - LB 0x29 -> rdata_o=0x00000033.
  - LB 0x2A -> 0xFFFFFFFF; LBU 0x2A -> 0x000000FF.
  - LH 0x2A -> 0xFFFF80FF... correction: LH 0x2A selects the upper half 0x80FF -> 0xFFFF80FF; LHU 0x2A -> 0x000080FF.
  - Each load: done_o exactly 3 clocks after accept.
- SW 0xDEADBEEF to 0x10 -> word 4=0xDEADBEEF; mem_wr_o low exactly 1 cycle; done_o after 2 clocks.
- Then SB 0xA5 to 0x13 -> word 4=0xA5ADBEEF. Then SH 0x1234 to 0x10 -> 0xA5AD1234. Each: done_o after 4 clocks.
- LH 0x11, LW 0x12, size 11 -> misalign_o=done_o=1 one cycle after accept; mem_wr_o never low; memory and rdata_o unchanged.
- reset_ni=0 during RD of SB 0x77 to 0x10 -> IDLE next cycle, busy_o=0, mem_wr_o=1, word 4 unchanged.
- req_i held high for 3 consecutive loads -> each accepted only from IDLE; extra req_i while busy causes no extra access; exactly 3 done_o pulses.
